// File: rtl/edgcol_pkg.sv
// Shared definitions for the edge-collision sequencer: state encoding,
// accelerator result width and the default watchdog length.
package edgcol_pkg;

    localparam int RESULT_WIDTH           = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4
    } seq_state_e;

    // A watchdog of N cycles needs ceil(log2(N)) bits, but never fewer than one.
    function automatic int counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/edgcol_sequencer_if.sv
// Handshake and operand bus between the sequencer (master) and the
// edge-collision accelerator (slave).
interface edgcol_sequencer_if #(
    parameter int BUS_WIDTH = 32
);
    import edgcol_pkg::*;

    logic                    apStart;
    logic                    apRst;
    logic                    apReady;
    logic                    apDone;
    logic [RESULT_WIDTH-1:0] apReturn;
    logic [BUS_WIDTH-1:0]    edgeP1X;
    logic [BUS_WIDTH-1:0]    edgeP1Y;
    logic [BUS_WIDTH-1:0]    edgeP1Z;
    logic [BUS_WIDTH-1:0]    edgeP2X;
    logic [BUS_WIDTH-1:0]    edgeP2Y;
    logic [BUS_WIDTH-1:0]    edgeP2Z;

    modport master (
        output apStart, apRst,
        output edgeP1X, edgeP1Y, edgeP1Z, edgeP2X, edgeP2Y, edgeP2Z,
        input  apReady, apDone, apReturn
    );

    modport slave (
        input  apStart, apRst,
        input  edgeP1X, edgeP1Y, edgeP1Z, edgeP2X, edgeP2Y, edgeP2Z,
        output apReady, apDone, apReturn
    );

endinterface

// File: rtl/edgcol_timeout_counter.sv
// Saturating watchdog counter: counts enabled cycles after a clear and flags
// the last cycle an operation is allowed to take.
module edgcol_timeout_counter
    import edgcol_pkg::*;
#(
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int WIDTH          = counter_width(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ena,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES - 1);

    // Stops at LIMIT so a stalled accelerator keeps the expired flag asserted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (ena && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/edgcol_sequencer.sv
// Edge-collision sequencer: latches six edge operands, launches the collision
// accelerator, waits for its result under a watchdog and reports back.
module edgcol_sequencer
    import edgcol_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    startReq,
    input  logic [BUS_WIDTH-1:0]    e0,
    input  logic [BUS_WIDTH-1:0]    e1,
    input  logic [BUS_WIDTH-1:0]    e2,
    input  logic [BUS_WIDTH-1:0]    e3,
    input  logic [BUS_WIDTH-1:0]    e4,
    input  logic [BUS_WIDTH-1:0]    e5,
    edgcol_sequencer_if.master      acc,
    output logic                    busy,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] collision,
    output logic                    timeout
);

    localparam int                   CNT_WIDTH = counter_width(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_e           state;
    seq_state_e           next_state;
    logic                 start_accept;
    logic                 cnt_ena;
    logic                 expired;
    logic                 capture;
    logic                 abort_entry;
    logic [CNT_WIDTH-1:0] count;

    assign start_accept = (state == ST_IDLE) && startReq;
    assign cnt_ena      = (state == ST_LAUNCH) || (state == ST_WAIT);
    assign capture      = (next_state == ST_DONE);
    assign abort_entry  = (next_state == ST_ABORT);

    edgcol_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_accept),
        .ena    (cnt_ena),
        .count  (count),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A result arriving on the watchdog's last cycle still counts as a completion.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (startReq) begin
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (acc.apReady && acc.apDone) begin
                    next_state = ST_DONE;
                end else if (expired) begin
                    next_state = acc.apDone ? ST_DONE : ST_ABORT;
                end else if (acc.apReady) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (acc.apDone) begin
                    next_state = ST_DONE;
                end else if (expired) begin
                    next_state = ST_ABORT;
                end
            end
            ST_DONE, ST_ABORT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // A core reset also resets the accelerator.
    always_comb begin
        acc.apStart = 1'b0;
        acc.apRst   = rst;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LAUNCH: begin
                acc.apStart = 1'b1;
            end
            ST_WAIT: begin
                acc.apStart = 1'b0;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            ST_ABORT: begin
                done      = 1'b1;
                acc.apRst = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operands are only loaded on acceptance, so they stay put for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc.edgeP1X <= '0;
            acc.edgeP1Y <= '0;
            acc.edgeP1Z <= '0;
            acc.edgeP2X <= '0;
            acc.edgeP2Y <= '0;
            acc.edgeP2Z <= '0;
            collision   <= '0;
            timeout     <= 1'b0;
        end else begin
            if (start_accept) begin
                acc.edgeP1X <= e0;
                acc.edgeP1Y <= e1;
                acc.edgeP1Z <= e2;
                acc.edgeP2X <= e3;
                acc.edgeP2Y <= e4;
                acc.edgeP2Z <= e5;
                timeout     <= 1'b0;
            end
            if (capture) begin
                collision <= acc.apReturn;
            end else if (abort_entry) begin
                collision <= '0;
                timeout   <= 1'b1;
            end
        end
    end

    count_full_on_abort: assert property (
        @(posedge clk) disable iff (rst) (state == ST_ABORT) |-> (count == CNT_LIMIT)
    );

endmodule

// File: tb/tb_edgcol_sequencer.sv
// Randomized scoreboard bench for edgcol_sequencer; expected completions come
// from a cycle-count model of the launch/wait/watchdog rules.
module tb_edgcol_sequencer;
    import edgcol_pkg::*;

    localparam int BW = 32;
    localparam int T  = 16;

    typedef struct {
        logic [RESULT_WIDTH-1:0] collision;
        logic                    timeout;
        logic                    aprst;
        int                      cycle;
    } sb_entry_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    startReq;
    logic [BW-1:0]           e0, e1, e2, e3, e4, e5;
    logic                    busy;
    logic                    done;
    logic                    timeout;
    logic [RESULT_WIDTH-1:0] collision;

    edgcol_sequencer_if #(.BUS_WIDTH(BW)) acc_bus ();

    int                      total = 0;
    int                      bad   = 0;
    int                      cyc   = 0;
    sb_entry_t               sb[$];
    sb_entry_t               mon_entry;
    logic [RESULT_WIDTH-1:0] prev_collision;

    edgcol_sequencer #(
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .startReq (startReq),
        .e0       (e0),
        .e1       (e1),
        .e2       (e2),
        .e3       (e3),
        .e4       (e4),
        .e5       (e5),
        .acc      (acc_bus),
        .busy     (busy),
        .done     (done),
        .collision(collision),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkEdges(input string tag, input logic [5:0][BW-1:0] want);
        logic [5:0][BW-1:0] got;
        got = {acc_bus.edgeP2Z, acc_bus.edgeP2Y, acc_bus.edgeP2X,
               acc_bus.edgeP1Z, acc_bus.edgeP1Y, acc_bus.edgeP1X};
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("%s_edge%0d", tag, i), 64'(got[i]), 64'(want[i]));
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("done_without_pending_op", 64'(done), 64'd0);
            end else begin
                mon_entry = sb.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(mon_entry.cycle));
                checkOutput("done_collision", collision, mon_entry.collision);
                checkOutput("done_timeout", 64'(timeout), 64'(mon_entry.timeout));
                checkOutput("done_aprst", 64'(acc_bus.apRst), 64'(mon_entry.aprst));
            end
        end
    end

    // One operation: accelerator takes operands at cycle r and answers at cycle d
    // (d < 0: never), counted from the first launch cycle. rst_k >= 0 resets mid-flight.
    task automatic applyStimulus(input logic [5:0][BW-1:0] ops, input int r, input int d,
                                 input logic [63:0] ret, input bit hold, input int rst_k);
        bit          aborted;
        int          last;
        logic [63:0] result;
        sb_entry_t   ent;
        bit          was_reset;

        was_reset = 1'b0;
        aborted   = !(d >= 0 && d <= T - 1);
        last      = aborted ? T : d + 1;
        result    = aborted ? 64'd0 : ret;

        startReq = 1'b1;
        {e5, e4, e3, e2, e1, e0} = ops;
        if (rst_k < 0) begin
            ent.collision = result;
            ent.timeout   = aborted;
            ent.aprst     = aborted;
            ent.cycle     = cyc + 1 + last;
            sb.push_back(ent);
        end

        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) startReq = 1'b0;
            {e5, e4, e3, e2, e1, e0} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            acc_bus.apReturn = {$urandom, $urandom};
            if (k < last) begin
                acc_bus.apReady = (k >= r);
                acc_bus.apDone  = (k == d);
                if (k == d) acc_bus.apReturn = ret;
            end else begin
                acc_bus.apReady = 1'($urandom_range(0, 1));
                acc_bus.apDone  = 1'($urandom_range(0, 1));
            end

            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                checkOutput("aprst_during_rst", 64'(acc_bus.apRst), 64'd1);
                @(posedge clk);
                @(negedge clk);
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                checkOutput("rst_apstart", 64'(acc_bus.apStart), 64'd0);
                checkOutput("rst_timeout", 64'(timeout), 64'd0);
                checkOutput("rst_collision", collision, 64'd0);
                checkEdges("rst", '0);
                rst             = 1'b0;
                acc_bus.apReady = 1'b0;
                acc_bus.apDone  = 1'b0;
                prev_collision  = '0;
                was_reset       = 1'b1;
                break;
            end

            checkOutput($sformatf("apstart_k%0d", k), 64'(acc_bus.apStart), 64'(k < last && k <= r));
            checkOutput($sformatf("busy_k%0d", k), 64'(busy), 64'd1);
            checkOutput($sformatf("done_k%0d", k), 64'(done), 64'(k == last));
            checkOutput($sformatf("aprst_k%0d", k), 64'(acc_bus.apRst), 64'(k == last && aborted));
            checkOutput($sformatf("timeout_k%0d", k), 64'(timeout), 64'(k == last && aborted));
            checkOutput($sformatf("collision_k%0d", k), collision, (k == last) ? result : prev_collision);
            checkEdges("held", ops);
        end

        if (!was_reset) begin
            @(posedge clk);
            @(negedge clk);
            acc_bus.apDone = 1'($urandom_range(0, 1));
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_apstart", 64'(acc_bus.apStart), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("idle_aprst", 64'(acc_bus.apRst), 64'd0);
            checkOutput("idle_timeout", 64'(timeout), 64'(aborted));
            checkOutput("idle_collision", collision, result);
            prev_collision = result;
        end
    endtask

    initial begin
        logic [5:0][BW-1:0] ops;
        int                 r;
        int                 d;

        rst              = 1'b1;
        startReq         = 1'b0;
        {e5, e4, e3, e2, e1, e0} = '0;
        acc_bus.apReady  = 1'b0;
        acc_bus.apDone   = 1'b0;
        acc_bus.apReturn = '0;
        prev_collision   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_apstart", 64'(acc_bus.apStart), 64'd0);
        checkOutput("reset_aprst", 64'(acc_bus.apRst), 64'd1);
        checkOutput("reset_timeout", 64'(timeout), 64'd0);
        checkOutput("reset_collision", collision, 64'd0);
        checkEdges("reset", '0);
        rst = 1'b0;
        #1;
        checkOutput("aprst_released", 64'(acc_bus.apRst), 64'd0);

        $display("[TB] basic operation, operands 1..6");
        for (int i = 0; i < 6; i++) ops[i] = BW'(i + 1);
        applyStimulus(ops, 1, 5, 64'h0000_0000_0000_0001, 1'b0, -1);

        $display("[TB] minimum latency");
        for (int i = 0; i < 6; i++) ops[i] = $urandom;
        applyStimulus(ops, 0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0, -1);

        $display("[TB] watchdog abort, then recovery");
        applyStimulus(ops, 2, -1, 64'h1234_5678_9ABC_DEF0, 1'b0, -1);
        applyStimulus(ops, 0, 2, 64'h0BAD_F00D_CAFE_0001, 1'b0, -1);
        applyStimulus(ops, T + 3, -1, 64'h5555_AAAA_5555_AAAA, 1'b0, -1);

        $display("[TB] completion on the last watchdog cycle");
        applyStimulus(ops, 0, T - 1, 64'hFEED_FACE_0000_0042, 1'b0, -1);
        applyStimulus(ops, T - 1, T - 1, 64'h0000_0042_FEED_FACE, 1'b0, -1);

        $display("[TB] reset while waiting");
        applyStimulus(ops, 0, -1, 64'h1111_2222_3333_4444, 1'b0, 3);
        for (int i = 0; i < 6; i++) ops[i] = $urandom;
        applyStimulus(ops, 1, 2, 64'h7777_8888_9999_AAAA, 1'b0, -1);

        $display("[TB] startReq held high");
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 6; i++) ops[i] = $urandom;
            applyStimulus(ops, 1, 3, {$urandom, $urandom}, n < 3, -1);
        end

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) d = -1;
            else d = r + int'($urandom_range(0, 12));
            for (int i = 0; i < 6; i++) ops[i] = $urandom;
            applyStimulus(ops, r, d, {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0) && (n < 39), -1);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
